// File: rtl/pgr_uart_tx_sched_32bit.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between two 32-bit word requesters.
// Words go out as 4 bytes, LSB byte first, each byte LSB first; bit timing counts clk_en ticks.
module pgr_uart_tx_sched_32bit #(
  parameter int TICKS_PER_BIT = 6,
  parameter int WORD_GAP      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        grant_id,
  output logic        busy,
  output logic        txd
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
  localparam logic [2:0] GAP_LAST  = 3'((WORD_GAP > 0) ? WORD_GAP - 1 : 0);

  state_t      state, state_nxt;
  logic [3:0]  tick_cnt, tick_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic [1:0]  byte_idx, byte_nxt;
  logic [31:0] shift_reg, shift_nxt;
  logic        last_grant, last_nxt, grant_nxt;
  logic        bit_end, win0, win1;

  assign bit_end = clk_en && (tick_cnt == TICK_LAST);
  // On a tie the requester that did not win last time goes first.
  assign win0    = req0_valid && (!req1_valid || last_grant);
  assign win1    = req1_valid && (!req0_valid || !last_grant);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    bit_nxt    = bit_idx;
    byte_nxt   = byte_idx;
    shift_nxt  = shift_reg;
    last_nxt   = last_grant;
    grant_nxt  = grant_id;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    txd        = 1'b1;
    if (state != IDLE)
      tick_nxt = bit_end ? 4'd0 : tick_cnt + 4'(clk_en);
    case (state)
      IDLE: begin
        tick_nxt = 4'd0;
        // rst_n gating keeps ready low while reset is held.
        if (rst_n && (win0 || win1)) begin
          req0_ready = win0;
          req1_ready = win1;
          shift_nxt  = win1 ? req1_data : req0_data;
          last_nxt   = win1;
          grant_nxt  = win1;
          bit_nxt    = 3'd0;
          byte_nxt   = 2'd0;
          state_nxt  = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (bit_end) begin
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        txd = shift_reg[0];
        if (bit_end) begin
          shift_nxt = {1'b0, shift_reg[31:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          byte_nxt = byte_idx + 2'd1;
          bit_nxt  = 3'd0;
          if (byte_idx == 2'd3) state_nxt = (WORD_GAP > 0) ? GAP : IDLE;
          else                  state_nxt = START;
        end
      end
      GAP: begin
        if (bit_end) begin
          if (bit_idx == GAP_LAST) state_nxt = IDLE;
          else                     bit_nxt   = bit_idx + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= 4'd0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
      shift_reg  <= 32'd0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_nxt;
      bit_idx    <= bit_nxt;
      byte_idx   <= byte_nxt;
      shift_reg  <= shift_nxt;
      last_grant <= last_nxt;
      grant_id   <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_pgr_uart_tx_sched_32bit.sv
// Bench for pgr_uart_tx_sched_32bit: randomized requesters against a pulse-counting line model,
// plus a directed word-gap measurement on a second instance with WORD_GAP=2.
module tb_pgr_uart_tx_sched_32bit;
  localparam int T     = 6;
  localparam int FRAME = 40 * T;

  logic        clk = 1'b0, rst_n = 1'b1, clk_en = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, grant_id, busy, txd;

  logic        g_valid = 1'b0;
  logic [31:0] g_data = '0;
  logic        g_ready, g_ready1, g_grant, g_busy, g_txd;

  int total = 0, bad = 0;

  pgr_uart_tx_sched_32bit #(.TICKS_PER_BIT(T), .WORD_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .grant_id(grant_id), .busy(busy), .txd(txd));

  pgr_uart_tx_sched_32bit #(.TICKS_PER_BIT(T), .WORD_GAP(2)) dut_gap (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req0_valid(g_valid), .req0_data(g_data), .req0_ready(g_ready),
    .req1_valid(1'b0), .req1_data(32'd0), .req1_ready(g_ready1),
    .grant_id(g_grant), .busy(g_busy), .txd(g_txd));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Line model: a frame is 40 bits of T pulses each, counted from the clk after acceptance.
  logic        m_busy = 1'b0, m_last = 1'b1, m_grant = 1'b0;
  int          m_n = 0;
  logic [31:0] m_word = '0;
  logic [1:0]  m_win;

  function automatic logic [1:0] arb(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  function automatic logic frame_bit(input logic [31:0] w, input int idx);
    int p;
    if (idx >= 40) return 1'b1;
    p = idx % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[(idx / 10) * 8 + p - 1];
  endfunction

  assign m_win = arb(req0_valid, req1_valid, m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_last  <= 1'b1;
      m_grant <= 1'b0;
      m_n     <= 0;
    end else if (!m_busy) begin
      if (m_win != 2'b00) begin
        m_busy  <= 1'b1;
        m_n     <= 0;
        m_last  <= m_win[1];
        m_grant <= m_win[1];
        m_word  <= m_win[1] ? req1_data : req0_data;
      end
    end else if (clk_en) begin
      m_n <= m_n + 1;
      if (m_n + 1 == FRAME) m_busy <= 1'b0;
    end
  end

  logic a0 = 1'b0, a1 = 1'b0;
  always @(negedge clk) begin
    a0 <= req0_ready;
    a1 <= req1_ready;
    chk("rdy0", req0_ready, (m_busy || !rst_n) ? 1'b0 : m_win[0]);
    chk("rdy1", req1_ready, (m_busy || !rst_n) ? 1'b0 : m_win[1]);
    chk("busy", busy, m_busy);
    chk("grant", grant_id, m_grant);
    chk("txd", txd, m_busy ? frame_bit(m_word, m_n / T) : 1'b1);
  end

  // Requester driver and clk_en generator (one pulse every 4 clk).
  logic [31:0] q0[$], q1[$];
  logic        mute_en = 1'b0;
  int          ph = 0;
  initial forever begin
    logic m0, m1;
    @(posedge clk); #1;
    ph     = (ph + 1) % 4;
    clk_en = (ph == 0);
    if (a0 && q0.size() > 0) void'(q0.pop_front());
    if (a1 && q1.size() > 0) void'(q1.pop_front());
    m0 = mute_en && ($urandom_range(0, 7) == 0);
    m1 = mute_en && ($urandom_range(0, 7) == 0);
    req0_valid = (q0.size() > 0) && !m0;
    req1_valid = (q1.size() > 0) && !m1;
    req0_data  = (q0.size() > 0) ? q0[0] : $urandom;
    req1_data  = (q1.size() > 0) ? q1[0] : $urandom;
  end

  task automatic wait_idle(input int max);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < max), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int n, pulses, run;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", {req1_ready, req0_ready}, 2'b00);
    chk("rst_grant", grant_id, 1'b0);
    #1 rst_n = 1'b1;

    q0.push_back(32'h12345678);
    wait_idle(3000);

    do_reset();
    q0.push_back(32'hAAAA5555);
    q1.push_back(32'h0F0F0F0F);
    wait_idle(6000);
    q0.push_back($urandom);
    q1.push_back($urandom);
    wait_idle(6000);

    repeat (4) q1.push_back($urandom);
    n = 0;
    while (!m_busy && n < 100) begin @(negedge clk); n++; end
    chk("t3_start", 32'(m_busy), 32'd1);
    repeat (300) @(negedge clk);
    #2 q0.push_back($urandom);
    wait_idle(15000);

    mute_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) != 0) q0.push_back($urandom);
      else                           q1.push_back($urandom);
      repeat ($urandom_range(0, 1500)) @(negedge clk);
    end
    wait_idle(20000);
    mute_en = 1'b0;

    // Reset during byte 2 of a frame.
    q0.push_back($urandom);
    n = 0;
    while (!(m_busy && m_n >= 25 * T) && n < 3000) begin @(negedge clk); n++; end
    chk("t5_reach_byte2", 32'(n < 3000), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_txd", txd, 1'b1);
    chk("t5_async_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    q0.push_back($urandom);
    q1.push_back($urandom);
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    chk("t5_tie_grant", grant_id, 1'b0);
    wait_idle(6000);

    // Word gap: two back-to-back words on the WORD_GAP=2 instance.
    @(posedge clk); #1;
    g_valid = 1'b1;
    g_data  = 32'h3C5A0F01;
    n = 0;
    do begin @(negedge clk); n++; end while (!g_ready && n < 100);
    chk("gap_first_accept", 32'(g_ready), 32'd1);
    @(posedge clk); #1 g_data = $urandom & 32'h7FFFFFFF;
    pulses = 0; run = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (g_ready) break;
      if (clk_en && g_busy) pulses++;
      if (!g_txd) run = 0;
      else if (clk_en) run++;
    end while (n < 3000);
    chk("gap_second_accept", 32'(g_ready), 32'd1);
    chk("gap_frame_pulses", pulses, FRAME + 2 * T);
    chk("gap_high_run", run, 3 * T);
    @(posedge clk); #1 g_valid = 1'b0;
    @(negedge clk);
    chk("gap_next_start", g_txd, 1'b0);
    chk("gap_next_busy", g_busy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
